// File: rtl/addsub_serial.sv
// Multi-cycle add/subtract: operands are shifted through a DIGIT-wide adder LSB-first.
// Define ADDSUB_SAT_EN to saturate s on signed overflow instead of wrapping.
module addsub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
endmodule

module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;

  logic [WIDTH-1:0] a_sh, b_sh, res, bx, s_pub;
  logic [CW-1:0]    cnt;
  logic             cy, a_msb, b_msb, done_q, ov_raw, accept;
  logic [DIGIT-1:0] dsum;
  logic             dcy;

  assign bx     = b ^ {WIDTH{mode}};
  // done_q keeps ready low for the cycle the result is published
  assign ready  = (state == IDLE) && !done_q;
  assign done   = done_q;
  assign accept = start && ready;

  addsub_digit #(.DIGIT(DIGIT)) u_dig (
    .a   (a_sh[DIGIT-1:0]),
    .b   (b_sh[DIGIT-1:0]),
    .cin (cy),
    .sum (dsum),
    .cout(dcy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = RUN;
      RUN:     if (cnt == CW'(N - 1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ov_raw = (a_msb == b_msb) && (res[WIDTH-1] != a_msb);
    s_pub  = res;
`ifdef ADDSUB_SAT_EN
    if (ov_raw) s_pub = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      cnt       <= '0;
      cy        <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      done_q    <= 1'b0;
      s         <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      case (state)
        IDLE: if (accept) begin
          a_sh  <= a;
          b_sh  <= bx;
          cy    <= mode;
          cnt   <= '0;
          a_msb <= a[WIDTH-1];
          b_msb <= bx[WIDTH-1];
        end
        RUN: begin
          a_sh <= a_sh >> DIGIT;
          b_sh <= b_sh >> DIGIT;
          // new digit enters at the top; after N digits the LSB digit sits at bit 0
          res  <= WIDTH'({dsum, res} >> DIGIT);
          cy   <= dcy;
          cnt  <= cnt + CW'(1);
        end
        DONE: begin
          s         <= s_pub;
          carry_out <= cy;
          overflow  <= ov_raw;
          zero      <= (s_pub == '0);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_serial.sv
// Random and directed checks of addsub_serial (8/1 and 16/4) against an integer-arithmetic model.
module tb_addsub_serial;
  logic        clk = 0, rst_n = 0, start = 0, mode = 0, sel = 0;
  logic [15:0] a = 0, b = 0;
  logic        start1, start2, rdy1, dn1, c1, v1, z1, rdy2, dn2, c2, v2, z2;
  logic [7:0]  s1;
  logic [15:0] s2;
  logic        rdy_m, dn_m, c_m, v_m, z_m;
  logic [15:0] s_m;
  logic [15:0] last_s[2];
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  assign start1 = start & ~sel;
  assign start2 = start & sel;
  assign rdy_m  = sel ? rdy2 : rdy1;
  assign dn_m   = sel ? dn2  : dn1;
  assign c_m    = sel ? c2   : c1;
  assign v_m    = sel ? v2   : v1;
  assign z_m    = sel ? z2   : z1;
  assign s_m    = sel ? s2   : {8'h00, s1};

  addsub_serial #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode), .a(a[7:0]), .b(b[7:0]),
    .ready(rdy1), .done(dn1), .s(s1), .carry_out(c1), .overflow(v1), .zero(z1));

  addsub_serial #(.WIDTH(16), .DIGIT(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode), .a(a), .b(b),
    .ready(rdy2), .done(dn2), .s(s2), .carry_out(c2), .overflow(v2), .zero(z2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on w-bit operands
  task automatic model(input int w, input logic [15:0] ai, input logic [15:0] bi, input bit mi,
                       output longint es, output bit ec, output bit ev, output bit ez);
    longint ua, ub, m, half, sa, sb, r;
    ua = longint'(ai); ub = longint'(bi);
    m = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    es = (mi ? ua - ub : ua + ub) & m;
    ec = mi ? (ua >= ub) : ((ua + ub) > m);
    sa = (ua >= half) ? ua - 2 * half : ua;
    sb = (ub >= half) ? ub - 2 * half : ub;
    r  = mi ? sa - sb : sa + sb;
    ev = (r >= half) || (r < -half);
`ifdef ADDSUB_SAT_EN
    if (ev) es = (r > 0) ? half - 1 : half;
`endif
    ez = (es == 0);
  endtask

  task automatic run_op(input logic [15:0] ai, input logic [15:0] bi, input bit mi, input bit poke);
    int n, j;
    longint es;
    bit ec, ev, ez, rdy_ok, hold_ok;
    n = sel ? 4 : 8;
    model(sel ? 16 : 8, ai, bi, mi, es, ec, ev, ez);
    rdy_ok = 1; hold_ok = 1;
    @(negedge clk);
    chk("ready_idle", rdy_m, 1);
    a = ai; b = bi; mode = mi; start = 1;
    @(negedge clk);
    start = 0; j = 0;
    while (!dn_m && j < 40) begin
      if (rdy_m) rdy_ok = 0;
      if (s_m !== last_s[sel]) hold_ok = 0;
      if (poke && j == 2) begin start = 1; a = 16'h0055; end
      else start = 0;
      @(negedge clk);
      j++;
    end
    start = 0;
    chk("latency", j, n + 1);
    chk("ready_low_run", rdy_ok, 1);
    chk("s_held_run", hold_ok, 1);
    chk("ready_low_done", rdy_m, 0);
    chk("s", s_m, es);
    chk("carry_out", c_m, ec);
    chk("overflow", v_m, ev);
    chk("zero", z_m, ez);
    last_s[sel] = es[15:0];
    @(negedge clk);
    chk("done_single", dn_m, 0);
    chk("ready_back", rdy_m, 1);
  endtask

  task automatic abort_op();
    bit saw;
    @(negedge clk);
    a = 16'h0012; b = 16'h0034; mode = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("abort_ready", rdy_m, 1);
    chk("abort_done", dn_m, 0);
    chk("abort_s", s_m, 0);
    chk("abort_flags", {c_m, v_m, z_m}, 0);
    last_s[0] = 0; last_s[1] = 0;
    saw = 0;
    repeat (15) begin
      @(negedge clk);
      if (dn_m) saw = 1;
    end
    chk("abort_no_done", saw, 0);
  endtask

  initial begin
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready1", rdy1, 1);
    chk("rst_done1", dn1, 0);
    chk("rst_s1", s1, 0);
    chk("rst_flags1", {c1, v1, z1}, 0);
    chk("rst_ready2", rdy2, 1);
    chk("rst_s2", s2, 0);
    rst_n = 1;
    last_s[0] = 0; last_s[1] = 0;

    sel = 0;
    run_op(16'h02, 16'h01, 1, 0);
    run_op(16'h00, 16'h01, 1, 0);
    run_op(16'hFF, 16'h01, 0, 0);
    run_op(16'h7F, 16'h01, 0, 0);
    run_op(16'h80, 16'h01, 1, 0);
    run_op(16'h00, 16'h80, 1, 0);
    run_op(16'h02, 16'h01, 1, 1);
    abort_op();
    run_op(16'h12, 16'h34, 0, 0);
    for (int i = 0; i < 40; i++)
      run_op(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);

    sel = 1;
    run_op(16'h1234, 16'h0235, 1, 0);
    run_op(16'h7FFF, 16'h0001, 0, 0);
    run_op(16'hFFFF, 16'h0001, 0, 0);
    for (int i = 0; i < 20; i++)
      run_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle add/subtract unit. It is the sequential successor to the team's 8-bit combinational subtractor. Operands are captured on a start handshake and processed LSB-first, DIGIT bits per clock. The result and status flags are returned with a one-cycle done pulse. It sits between the control FSM and the register file, where area matters more than single-cycle latency.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 2.
- DIGIT, 1: bits processed per clock; must divide WIDTH exactly. N = WIDTH/DIGIT.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; accepted only when ready=1.
- mode  in  1  0 = a+b, 1 = a−b; sampled with start.
- a  in  WIDTH  minuend/augend; sampled with start.
- b  in  WIDTH  subtrahend/addend; sampled with start.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse; s and the flags are valid from this cycle.
- s  out  WIDTH  result.
- carry_out  out  1  raw carry out of the MSB; for subtract, 1 = no borrow.
- overflow  out  1  two's-complement signed overflow.
- zero  out  1  s == 0.

## Operation
- Arithmetic: s = a + (b XOR {WIDTH{mode}}) + mode, modulo 2^WIDTH.
- carry_out is the carry out of bit WIDTH−1 of that sum.
- overflow = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is the post-XOR operand.
- FSM states: IDLE, RUN, DONE.
- IDLE: ready=1. On start=1, latch a, b' and mode into shift registers, set carry register = mode and digit counter = 0, then go to RUN.
- RUN:
  - Each cycle, add the low DIGIT bits of both shift registers plus the carry register.
  - Shift the sum digit into the result register from the MSB side.
  - Update carry; increment the counter.
  - After the N-th digit, go to DONE.
- DONE: done=1 for exactly one cycle. Publish the assembled result to s and the flags, then go to IDLE.
- s and the flags hold their values until the next DONE. They do not change during RUN.
- start while ready=0 is ignored. It is not queued.
- rst_n=0 in any state: at the next edge, go to IDLE and discard the in-flight operation. No done pulse is produced for it.

## Timing
- Reset values: ready=1, done=0, s=0, carry_out=0, overflow=0, zero=0, FSM=IDLE.
- Start accepted at edge k → ready=0 from edge k.
- Final digit is computed at edge k+N. done=1 and s/flags are updated at edge k+N+1, so they are visible during cycle k+N+1.
- ready returns to 1 at edge k+N+2. The next start can be accepted at that edge.
- Throughput: one operation per N+2 cycles.
- done is never high on two consecutive cycles.
- When start and rst_n=0 occur in the same cycle, reset wins.

## Configuration
- ADDSUB_SAT_EN defined: on signed overflow, s saturates instead of wrapping.
  - To 2^(WIDTH−1)−1 if a[MSB]=0.
  - To −2^(WIDTH−1) if a[MSB]=1.
  - overflow and carry_out still report the raw, unsaturated result.
  - zero is computed on the saturated s.
- Macro undefined: s wraps modulo 2^WIDTH. No saturation logic is present.

## Test plan
- WIDTH=8, DIGIT=1, sub 0x02−0x01 → done at edge k+9 with s=0x01, carry_out=1, overflow=0, zero=0. ready=0 for edges k..k+9.
- Sub 0x00−0x01 → s=0xFF, carry_out=0 (borrow), overflow=0. Add 0xFF+0x01 → s=0x00, carry_out=1, zero=1.
- Add 0x7F+0x01 → overflow=1; s=0x80 without ADDSUB_SAT_EN, 0x7F with it. Sub 0x80−0x01 → overflow=1; s=0x7F without the macro, 0x80 with it.
- Pulse start again at edge k+3 with a=0x55 → ignored. The first result completes unchanged, and only one done pulse occurs.
- rst_n=0 for one cycle at edge k+4 → ready=1, s=0 and all flags=0 after that edge. No done pulse follows; a fresh start afterwards completes normally.
- WIDTH=16, DIGIT=4, sub 0x1234−0x0235 → s=0x0FFF, carry_out=1, done at edge k+5.
